// File: rtl/sci_slave_if.sv
// sci_slave_if
// Serial Configuration Interface bundle between one SCI master and one neuron slave.
// SCI_RESP and SCI_ACK are open lines. The slave supplies a value and an output
// enable for each line, and the line is resolved to Z here whenever its enable is low.
//   SCI_CSN  : chip select, active low, driven by the master
//   SCI_REQ  : serial master-to-slave data, driven by the master
//   SCI_RESP : serial read data, resolved from resp_o / resp_oe
//   SCI_ACK  : frame-complete pulse, resolved from ack_o / ack_oe
interface sci_slave_if;
  logic SCI_CSN;
  logic SCI_REQ;
  logic resp_o;
  logic resp_oe;
  logic ack_o;
  logic ack_oe;
  wire  SCI_RESP;
  wire  SCI_ACK;

  // Only a selected, active slave puts a level on the shared lines.
  assign SCI_RESP = resp_oe ? resp_o : 1'bz;
  assign SCI_ACK  = ack_oe  ? ack_o  : 1'bz;

  modport slave (
    input  SCI_CSN,
    input  SCI_REQ,
    output resp_o,
    output resp_oe,
    output ack_o,
    output ack_oe
  );

  modport master (
    output SCI_CSN,
    output SCI_REQ,
    input  SCI_RESP,
    input  SCI_ACK,
    input  resp_oe,
    input  ack_oe
  );
endinterface

// File: rtl/sci_slave.sv
// sci_slave
// Serial Configuration Interface slave for one neuron. It takes a master frame
// (WNR bit, address, and write data for write frames) from SCI_REQ, MSB first.
// It turns the frame into one register-file write or read strobe. For a read it
// serialises the register value back on SCI_RESP. Every completed frame ends
// with a one-cycle ACK.
//   CLK, RST   : clock, synchronous active-high reset
//   sci        : SCI bus (CSN, REQ in; RESP, ACK drive value + enable out)
//   REG_WEN    : one-cycle write strobe
//   REG_REN    : one-cycle read strobe
//   REG_ADDR   : register address, held from the end of the address phase
//   REG_WDATA  : write data, valid with REG_WEN
//   REG_RDATA  : read data, valid one cycle after REG_REN
//   BUSY       : high whenever the FSM is not idle
//   ADDR_ERR   : sticky out-of-range access flag, cleared only by RST
module sci_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  sci_slave_if.slave            sci,
  output logic                  REG_WEN,
  output logic                  REG_REN,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  input  logic [DATA_WIDTH-1:0] REG_RDATA,
  output logic                  BUSY,
  output logic                  ADDR_ERR
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RX_ADDR = 4'd1;
  localparam logic [3:0] S_RX_DATA = 4'd2;
  localparam logic [3:0] S_WR      = 4'd3;
  localparam logic [3:0] S_RD_REQ  = 4'd4;
  localparam logic [3:0] S_RD_CAP  = 4'd5;
  localparam logic [3:0] S_TX      = 4'd6;
  localparam logic [3:0] S_ACK     = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  wnr_q, wnr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  selected;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] sh_in;

  assign selected = ~sci.SCI_CSN;
  assign sh_in    = {sh_q[DATA_WIDTH-2:0], sci.SCI_REQ};
  assign addr_ok  = (32'(addr_q) < 32'(NUM_REGS));

  // The receive phases shift SCI_REQ into sh_q. The last bit of a phase is
  // taken straight from sh_in, so address and data are complete on that edge.
  // In TX, sh_q is reused as the output shifter, emptied MSB first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    wnr_d   = wnr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (selected) begin
          wnr_d   = sci.SCI_REQ;
          cnt_d   = '0;
          state_d = S_RX_ADDR;
        end
      end
      S_RX_ADDR: begin
        sh_d  = sh_in;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == ADDR_LAST) begin
          addr_d  = sh_in[ADDR_WIDTH-1:0];
          cnt_d   = '0;
          state_d = wnr_q ? S_RX_DATA : S_RD_REQ;
        end
      end
      S_RX_DATA: begin
        sh_d  = sh_in;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DATA_LAST) begin
          wdata_d = sh_in;
          cnt_d   = '0;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!addr_ok) err_d = 1'b1;
        state_d = S_DONE;
      end
      S_RD_REQ: begin
        if (!addr_ok) err_d = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        // No read was issued for an out-of-range address, so shift out zeros.
        sh_d    = addr_ok ? REG_RDATA : '0;
        cnt_d   = '0;
        state_d = S_TX;
      end
      S_TX: begin
        sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!selected) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // If the master lets go of CSN mid-frame, drop the frame. A bit that
    // arrives on that same edge must not update the address, data or error.
    if (!selected && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      wnr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      wnr_q   <= wnr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // The strobes are gated by CSN. If a frame is aborted on the edge where the
  // register file would sample a strobe, the register file never sees it.
  assign REG_WEN   = (state_q == S_WR)     && selected && addr_ok;
  assign REG_REN   = (state_q == S_RD_REQ) && selected && addr_ok;
  assign REG_ADDR  = addr_q;
  assign REG_WDATA = wdata_q;
  assign BUSY      = (state_q != S_IDLE);
  assign ADDR_ERR  = err_q;

  assign sci.resp_oe = selected && (state_q != S_IDLE);
  assign sci.ack_oe  = selected && (state_q != S_IDLE);
  assign sci.resp_o  = (state_q == S_TX) ? sh_q[DATA_WIDTH-1] : 1'b0;
  assign sci.ack_o   = (state_q == S_WR) || (state_q == S_ACK);

endmodule

// File: tb/tb_sci_slave.sv
// tb_sci_slave
// Drives SCI frames at sci_slave as a master would. A small register-file
// model sits behind the slave. The bench predicts every strobe and ACK in a
// scoreboard queue, and a negedge monitor pops each entry as the slave produces it.
module tb_sci_slave;

  localparam int A     = 5;
  localparam int D     = 32;
  localparam int NREGS = 20;

  localparam int EV_WEN = 0;
  localparam int EV_REN = 1;
  localparam int EV_ACK = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sci_slave_if bus();

  logic         reg_wen, reg_ren, busy, addr_err;
  logic [A-1:0] reg_addr;
  logic [D-1:0] reg_wdata, reg_rdata, rd_value;

  sci_slave #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .NUM_REGS(NREGS)) dut (
    .CLK       (clk),
    .RST       (rst),
    .sci       (bus),
    .REG_WEN   (reg_wen),
    .REG_REN   (reg_ren),
    .REG_ADDR  (reg_addr),
    .REG_WDATA (reg_wdata),
    .REG_RDATA (reg_rdata),
    .BUSY      (busy),
    .ADDR_ERR  (addr_err)
  );

  // Register file model: read data is valid for exactly one cycle after
  // REG_REN, with all-ones garbage at every other time.
  always @(posedge clk) reg_rdata <= reg_ren ? rd_value : 32'hFFFF_FFFF;

  int cyc_cnt    = 0;
  int frame_base = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int           kind;
    int           cyc;
    logic [A-1:0] addr;
    logic [D-1:0] data;
  } ev_t;

  typedef struct {
    logic         wnr;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    int           abort_at;
    int           hold;
    logic         exp_strobe;
    logic [D-1:0] exp_resp;
    logic         exp_err;
  } vec_t;

  ev_t          exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [D-1:0] resp_word = '0;

  function automatic void expect_ev(int kind, int cyc, logic [A-1:0] addr, logic [D-1:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void match_event(int kind, int fc, logic [A-1:0] addr, logic [D-1:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event got kind=%0d cyc=%0d addr=%0h data=%h required no event",
               kind, fc, addr, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != fc || e.addr != addr || e.data != data) begin
      failures++;
      $display("[TB] FAIL event got kind=%0d cyc=%0d addr=%0h data=%h required kind=%0d cyc=%0d addr=%0h data=%h",
               kind, fc, addr, data, e.kind, e.cyc, e.addr, e.data);
    end
  endfunction

  function automatic void check_output(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h required=%h", name, got, exp);
    end
  endfunction

  // Monitor: events are sampled midway through the cycle whose closing edge
  // is frame cycle fc. RESP bits are collected so the word can be checked at ACK.
  always @(negedge clk) begin
    int fc;
    fc = cyc_cnt + 1 - frame_base;
    if (reg_wen) match_event(EV_WEN, fc, reg_addr, reg_wdata);
    if (reg_ren) match_event(EV_REN, fc, reg_addr, '0);
    if (bus.ack_oe && bus.SCI_ACK) match_event(EV_ACK, fc, '0, resp_word);
    else resp_word = {resp_word[D-2:0], bus.resp_oe & bus.SCI_RESP};
  end

  // Sends one frame, starting just after a posedge. The frame is cut short
  // after abort_at bits when abort_at is nonzero. Once the ACK edge has
  // passed, CSN stays low for hold more cycles with random REQ. The task then
  // raises CSN for exactly one edge and returns just after that edge.
  task automatic apply_stimulus(input vec_t v);
    logic [D+A:0] bits;
    int           nbits, ack_cyc, last;
    bits    = {v.wnr, v.addr, v.data};
    nbits   = v.wnr ? 1 + A + D : 1 + A;
    ack_cyc = v.wnr ? A + D + 1 : A + D + 3;
    rd_value = v.data;
    if (v.abort_at == 0) begin
      if (v.exp_strobe) begin
        if (v.wnr) expect_ev(EV_WEN, A + D + 1, v.addr, v.data);
        else       expect_ev(EV_REN, A + 1, v.addr, '0);
      end
      expect_ev(EV_ACK, ack_cyc, '0, v.exp_resp);
      last = ack_cyc + v.hold;
    end else begin
      last = v.abort_at - 1;
    end
    frame_base  = cyc_cnt + 1;
    bus.SCI_CSN = 1'b0;
    for (int k = 0; k <= last; k++) begin
      bus.SCI_REQ = (k < nbits) ? bits[D+A-k] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.SCI_CSN = 1'b1;
    #4;
    check_output("bus_z_after_csn", {62'd0, bus.resp_oe, bus.ack_oe}, 64'd0);
    @(posedge clk); #1;
    check_output("busy_idle", {63'd0, busy}, 64'd0);
    check_output("missing_event", 64'(exp_q.size()), 64'd0);
    check_output("reg_addr_held", {59'd0, reg_addr}, {59'd0, v.addr});
    check_output("addr_err", {63'd0, addr_err}, {63'd0, v.exp_err});
    if (v.wnr && v.exp_strobe)
      check_output("reg_wdata_held", {32'd0, reg_wdata}, {32'd0, v.data});
  endtask

  vec_t vecs[9];
  vec_t v;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.SCI_CSN = 1'b1;
    bus.SCI_REQ = 1'b0;
    rd_value    = '0;

    //             wnr   addr   data          abort hold strobe resp          err
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 0,  4,   1'b1, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 5'd7,  32'hA5A50F0F, 0,  0,   1'b1, 32'hA5A50F0F, 1'b0};
    vecs[2] = '{1'b1, 5'd19, 32'h12345678, 0,  0,   1'b1, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h80000001, 0,  0,   1'b1, 32'h80000001, 1'b0};
    vecs[4] = '{1'b1, 5'd9,  32'h0F0F1234, 16, 0,   1'b0, 32'h0,        1'b0};
    vecs[5] = '{1'b1, 5'd1,  32'hCAFEF00D, 0,  0,   1'b1, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 5'd20, 32'h5555AAAA, 0,  0,   1'b0, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 5'd25, 32'h11112222, 0,  0,   1'b0, 32'h0,        1'b1};
    vecs[8] = '{1'b0, 5'd25, 32'h33334444, 0,  2,   1'b0, 32'h0,        1'b1};

    // Reset values, with CSN low so that the bus still has to stay Z.
    repeat (2) @(posedge clk);
    bus.SCI_CSN = 1'b0;
    #1;
    check_output("reset_outputs",
                 {57'd0, reg_wen, reg_ren, busy, addr_err, bus.resp_oe, bus.ack_oe, 1'b0},
                 64'd0);
    check_output("reset_addr_data", {27'd0, reg_addr, reg_wdata}, 64'd0);
    bus.SCI_CSN = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

    // Deselected: a frame's worth of REQ toggling with CSN held high.
    for (int k = 0; k < 40; k++) begin
      bus.SCI_REQ = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_output("deselected_quiet",
                   {59'd0, busy, bus.resp_oe, bus.ack_oe, reg_wen, reg_ren}, 64'd0);
    end

    // Reset in the middle of a read's TX phase. The read strobe has already
    // been issued, but no ACK may follow.
    v = '{1'b0, 5'd7, 32'h13579BDF, 0, 0, 1'b1, 32'h0, 1'b0};
    rd_value = v.data;
    expect_ev(EV_REN, A + 1, v.addr, '0);
    frame_base  = cyc_cnt + 1;
    bus.SCI_CSN = 1'b0;
    for (int k = 0; k < A + 10; k++) begin
      bus.SCI_REQ = (k == 0) ? v.wnr : v.addr[A-k];
      if (k > A) bus.SCI_REQ = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("midreset_outputs",
                 {58'd0, busy, bus.resp_oe, bus.ack_oe, reg_wen, reg_ren, addr_err}, 64'd0);
    check_output("midreset_addr_data", {27'd0, reg_addr, reg_wdata}, 64'd0);
    bus.SCI_CSN = 1'b1;
    check_output("midreset_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Back-to-back write then read, with one CSN-high edge between them.
    v = '{1'b1, 5'd2, 32'h0BADF00D, 0, 0, 1'b1, 32'h0, 1'b0};
    apply_stimulus(v);
    v = '{1'b0, 5'd2, 32'h6C6C3939, 0, 0, 1'b1, 32'h6C6C3939, 1'b0};
    apply_stimulus(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
